measurement_word_receiver: RTL and testbench

- Receive-side counterpart of the measurement output serializer. It accepts a selection command, then collects the byte stream that the serializer returns for that command.
- Bytes arrive MSB-first. The block reassembles them into one COUNTER_BITS word and writes it to the matching time_high/time_low/period register.
- Used on the host-side fabric and as the loopback checker for the pulse-width counter data path.
- Includes inter-byte timeout resynchronisation and error flags.

---
 rtl/measurement_word_receiver_if.sv | 20 ++
 rtl/measurement_word_receiver.sv | 122 ++++++++++++
 tb/tb_measurement_word_receiver.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/measurement_word_receiver_if.sv
// rtl/measurement_word_receiver_if.sv - command and byte-stream handshake bundle for the word receiver
interface measurement_word_receiver_if #(
  parameter int DATA_WIDTH = 8
);
  logic [7:0]            cmd_data;
  logic                  cmd_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output cmd_data, cmd_valid, rx_data, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  cmd_data, cmd_valid, rx_data, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/measurement_word_receiver.sv
// rtl/measurement_word_receiver.sv - reassembles MSB-first bytes into time_high/time_low/period words
module measurement_word_receiver #(
  parameter int COUNTER_BITS   = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  measurement_word_receiver_if.slave   bus,
  output logic [COUNTER_BITS-1:0]      time_high,
  output logic [COUNTER_BITS-1:0]      time_low,
  output logic [COUNTER_BITS-1:0]      period,
  output logic                         word_valid,
  output logic [1:0]                   word_sel,
  output logic                         busy,
  output logic                         cmd_err,
  output logic                         stray_byte,
  output logic                         timeout_err
);
  localparam int NBYTES = COUNTER_BITS / DATA_WIDTH;
  localparam int CNT_W  = $clog2(NBYTES) + 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int SH_W   = COUNTER_BITS - DATA_WIDTH;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t            state, state_next;
  logic [SH_W-1:0]   shreg;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [1:0]        sel;

  logic                    byte_take;
  logic                    cmd_ok;
  logic                    last_byte;
  logic                    expire;
  logic [COUNTER_BITS-1:0] full_word;

  assign byte_take = bus.rx_valid && bus.rx_ready;
  assign cmd_ok    = (bus.cmd_data <= 8'd2);
  assign last_byte = byte_take && (byte_cnt == CNT_W'(NBYTES - 1));
  // An arriving byte always beats an expiring timeout in the same cycle.
  assign expire    = !byte_take && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign full_word = {shreg, bus.rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.rx_ready = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        bus.rx_ready = 1'b1;
        if (bus.cmd_valid && cmd_ok) state_next = COLLECT;
      end
      COLLECT: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (last_byte || expire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg       <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      sel         <= 2'd0;
      time_high   <= '0;
      time_low    <= '0;
      period      <= '0;
      word_sel    <= 2'd0;
      word_valid  <= 1'b0;
      cmd_err     <= 1'b0;
      stray_byte  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      word_valid  <= 1'b0;
      cmd_err     <= 1'b0;
      stray_byte  <= 1'b0;
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (bus.cmd_valid) begin
          if (cmd_ok) begin
            sel      <= bus.cmd_data[1:0];
            byte_cnt <= '0;
            to_cnt   <= '0;
          end else begin
            cmd_err <= 1'b1;
          end
        end
        if (byte_take) stray_byte <= 1'b1;
      end else begin
        if (byte_take) begin
          shreg    <= full_word[SH_W-1:0];
          byte_cnt <= byte_cnt + CNT_W'(1);
          to_cnt   <= '0;
          if (last_byte) begin
            case (sel)
              2'd0:    time_high <= full_word;
              2'd1:    time_low  <= full_word;
              2'd2:    period    <= full_word;
              default: ;
            endcase
            word_sel   <= sel;
            word_valid <= 1'b1;
          end
        end else if (expire) begin
          timeout_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_measurement_word_receiver.sv
// tb/tb_measurement_word_receiver.sv - directed vector bench for measurement_word_receiver
module tb_measurement_word_receiver;
  logic clk;
  logic rst_n;
  logic [31:0] time_high, time_low, period;
  logic        word_valid, busy, cmd_err, stray_byte, timeout_err;
  logic [1:0]  word_sel;

  int checks = 0;
  int errors = 0;

  measurement_word_receiver_if #(.DATA_WIDTH(8)) bus ();

  measurement_word_receiver #(
    .COUNTER_BITS(32), .DATA_WIDTH(8), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .time_high(time_high), .time_low(time_low), .period(period),
    .word_valid(word_valid), .word_sel(word_sel), .busy(busy),
    .cmd_err(cmd_err), .stray_byte(stray_byte), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [7:0]  cd;
    logic        rv;
    logic [7:0]  rd;
    logic        wv;
    logic [1:0]  ws;
    logic        bsy;
    logic        ce;
    logic        sb;
    logic        te;
    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] pe;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic cv, input logic [7:0] cd, input logic rv, input logic [7:0] rd,
                              input logic wv, input logic [1:0] ws, input logic bsy, input logic ce,
                              input logic sb, input logic te, input logic [31:0] th, input logic [31:0] tl,
                              input logic [31:0] pe);
    vec_t v;
    v.cv = cv; v.cd = cd; v.rv = rv; v.rd = rd;
    v.wv = wv; v.ws = ws; v.bsy = bsy; v.ce = ce; v.sb = sb; v.te = te;
    v.th = th; v.tl = tl; v.pe = pe;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic wv, input logic [1:0] ws, input logic bsy,
                           input logic ce, input logic sb, input logic te,
                           input logic [31:0] th, input logic [31:0] tl, input logic [31:0] pe);
    check({tag, "_word_valid"},  32'(word_valid),  32'(wv));
    check({tag, "_word_sel"},    32'(word_sel),    32'(ws));
    check({tag, "_busy"},        32'(busy),        32'(bsy));
    check({tag, "_cmd_err"},     32'(cmd_err),     32'(ce));
    check({tag, "_stray_byte"},  32'(stray_byte),  32'(sb));
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'(te));
    check({tag, "_time_high"},   time_high, th);
    check({tag, "_time_low"},    time_low,  tl);
    check({tag, "_period"},      period,    pe);
    check({tag, "_rx_ready"},    32'(bus.rx_ready), 32'd1);
  endtask

  task automatic step(input logic cv, input logic [7:0] cd, input logic rv, input logic [7:0] rd);
    bus.cmd_valid = cv;
    bus.cmd_data  = cd;
    bus.rx_valid  = rv;
    bus.rx_data   = rd;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.rx_valid  = 1'b0;
  endtask

  localparam logic [31:0] TH1 = 32'h12345678;
  localparam logic [31:0] TL1 = 32'h87654321;
  localparam logic [31:0] TH2 = 32'h01020304;
  localparam logic [31:0] TL2 = 32'h11223344;
  localparam logic [31:0] TH3 = 32'h10203040;

  initial begin
    logic [7:0] gap_bytes [4];
    logic [7:0] tail_bytes [3];
    gap_bytes  = '{8'h87, 8'h65, 8'h43, 8'h21};
    tail_bytes = '{8'h20, 8'h30, 8'h40};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_data = 8'd0;
    bus.rx_valid  = 1'b0; bus.rx_data  = 8'd0;

    // Consecutive bytes into time_high
    add(1, 8'd0, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8'd0, 1, 8'h12, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8'd0, 1, 8'h34, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8'd0, 1, 8'h56, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 8'd0, 1, 8'h78, 1, 0, 0, 0, 0, 0, TH1, 0, 0);
    add(0, 8'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0, TH1, 0, 0);
    // Gapped bytes into time_low
    add(1, 8'd1, 0, 8'h00, 0, 0, 1, 0, 0, 0, TH1, 0, 0);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) begin
        add(0, 8'd0, 1, gap_bytes[b], 1, 1, 0, 0, 0, 0, TH1, TL1, 0);
      end else begin
        add(0, 8'd0, 1, gap_bytes[b], 0, 0, 1, 0, 0, 0, TH1, 0, 0);
        for (int g = 0; g < 3; g++) add(0, 8'd0, 0, 8'h00, 0, 0, 1, 0, 0, 0, TH1, 0, 0);
      end
    end
    add(0, 8'd0, 0, 8'h00, 0, 1, 0, 0, 0, 0, TH1, TL1, 0);
    // Bad command, then stray byte
    add(1, 8'd3, 0, 8'h00, 0, 1, 0, 1, 0, 0, TH1, TL1, 0);
    add(0, 8'd0, 0, 8'h00, 0, 1, 0, 0, 0, 0, TH1, TL1, 0);
    add(0, 8'd0, 1, 8'h5A, 0, 1, 0, 0, 1, 0, TH1, TL1, 0);
    add(0, 8'd0, 0, 8'h00, 0, 1, 0, 0, 0, 0, TH1, TL1, 0);
    // Command during COLLECT is ignored
    add(1, 8'd0, 0, 8'h00, 0, 1, 1, 0, 0, 0, TH1, TL1, 0);
    add(0, 8'd0, 1, 8'h01, 0, 1, 1, 0, 0, 0, TH1, TL1, 0);
    add(0, 8'd0, 1, 8'h02, 0, 1, 1, 0, 0, 0, TH1, TL1, 0);
    add(1, 8'd1, 1, 8'h03, 0, 1, 1, 0, 0, 0, TH1, TL1, 0);
    add(0, 8'd0, 1, 8'h04, 1, 0, 0, 0, 0, 0, TH2, TL1, 0);
    add(0, 8'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0, TH2, TL1, 0);
    // Command and byte together in IDLE: command taken, byte stray
    add(1, 8'd1, 1, 8'h99, 0, 0, 1, 0, 1, 0, TH2, TL1, 0);
    add(0, 8'd0, 1, 8'h11, 0, 0, 1, 0, 0, 0, TH2, TL1, 0);
    add(0, 8'd0, 1, 8'h22, 0, 0, 1, 0, 0, 0, TH2, TL1, 0);
    add(0, 8'd0, 1, 8'h33, 0, 0, 1, 0, 0, 0, TH2, TL1, 0);
    add(0, 8'd0, 1, 8'h44, 1, 1, 0, 0, 0, 0, TH2, TL2, 0);
    add(0, 8'd0, 0, 8'h00, 0, 1, 0, 0, 0, 0, TH2, TL2, 0);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].cv, vecs[i].cd, vecs[i].rv, vecs[i].rd);
      check_all($sformatf("vec%0d", i), vecs[i].wv, vecs[i].ws, vecs[i].bsy, vecs[i].ce,
                vecs[i].sb, vecs[i].te, vecs[i].th, vecs[i].tl, vecs[i].pe);
    end

    // Timeout after 1024 idle cycles, then a clean period collection
    step(1, 8'd2, 0, 8'h00);
    step(0, 8'd0, 1, 8'hAB);
    step(0, 8'd0, 1, 8'hCD);
    for (int k = 1; k <= 1024; k++) begin
      step(0, 8'd0, 0, 8'h00);
      if (k == 1023) check_all("to_pre", 0, 1, 1, 0, 0, 0, TH2, TL2, 0);
      if (k == 1024) check_all("to_hit", 0, 1, 0, 0, 0, 1, TH2, TL2, 0);
    end
    step(0, 8'd0, 0, 8'h00);
    check_all("to_post", 0, 1, 0, 0, 0, 0, TH2, TL2, 0);
    step(1, 8'd2, 0, 8'h00);
    step(0, 8'd0, 1, 8'hAB);
    step(0, 8'd0, 1, 8'hCD);
    step(0, 8'd0, 1, 8'hEF);
    step(0, 8'd0, 1, 8'h01);
    check_all("period", 1, 2, 0, 0, 0, 0, TH2, TL2, 32'hABCDEF01);

    // A byte arriving exactly at expiry is accepted
    step(1, 8'd0, 0, 8'h00);
    for (int k = 0; k < 1023; k++) step(0, 8'd0, 0, 8'h00);
    step(0, 8'd0, 1, 8'h10);
    check_all("edge_byte", 0, 2, 1, 0, 0, 0, TH2, TL2, 32'hABCDEF01);
    foreach (tail_bytes[b]) step(0, 8'd0, 1, tail_bytes[b]);
    check_all("edge_done", 1, 0, 0, 0, 0, 0, TH3, TL2, 32'hABCDEF01);

    // Reset mid-collection discards the partial word
    step(1, 8'd0, 0, 8'h00);
    step(0, 8'd0, 1, 8'h11);
    step(0, 8'd0, 1, 8'h22);
    rst_n = 1'b0;
    #2;
    check_all("mid_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 8'd0, 0, 8'h00);
    step(0, 8'd0, 1, 8'hDE);
    check_all("rs_de", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 8'd0, 1, 8'hAD);
    check_all("rs_ad", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 8'd0, 1, 8'hBE);
    check_all("rs_be", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 8'd0, 1, 8'hEF);
    check_all("rs_ef", 1, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
